mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles without mem_ready before abort (1..255).
REQ-004 Parameter MAX_DBURST, default 4: consecutive D grants allowed while I is pending.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-008 i_addr  in  AW  fetch address (PC).
REQ-009 i_rdata  out  DW  fetch data, valid when i_ack.
REQ-010 i_ack  out  1  fetch complete, single cycle.
REQ-011 i_err  out  1  fetch aborted by timeout, qualifies i_ack.
REQ-012 d_req  in  1  data-access request, held until d_ack.
REQ-013 d_we  in  1  1 = store, 0 = load.
REQ-014 d_addr  in  AW  data address (ALU result).
REQ-015 d_wdata  in  DW  store data.
REQ-016 d_rdata  out  DW  load data, valid when d_ack.
REQ-017 d_ack  out  1  data access complete, single cycle.
REQ-018 d_err  out  1  data access aborted by timeout, qualifies d_ack.
REQ-019 mem_req  out  1  request to the single-port memory.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_addr  out  AW  memory address.
REQ-022 mem_wdata  out  DW  memory write data.
REQ-023 mem_rdata  in  DW  memory read data, valid with mem_ready.
REQ-024 mem_ready  in  1  memory completes the current access.

Function
REQ-025 The FSM SHALL have three states: IDLE, IBUSY, DBUSY.
REQ-026 IDLE: d_req only -> DBUSY; i_req only -> IBUSY; both -> DBUSY unless dburst_cnt == MAX_DBURST, in which case -> IBUSY; neither -> stay.
REQ-027 On grant, the grantee's address, d_we and d_wdata SHALL be latched into mem_addr, mem_we and mem_wdata; for IBUSY, mem_we = 0.
REQ-028 mem_req SHALL be 1 exactly when the state is IBUSY or DBUSY, so the first mem_req cycle is the cycle after grant.
REQ-029 In xBUSY with mem_ready = 1: x_ack = 1 combinationally, x_rdata = mem_rdata (0 for stores), x_err = 0, and the next state is IDLE.
REQ-030 Every ack SHALL be followed by a 1-cycle IDLE turnaround, giving a minimum of 2 cycles per access.
REQ-031 The requester SHALL drop or replace its request the cycle after its ack; the arbiter SHALL NOT inspect req in BUSY states.
REQ-032 A wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready = 0.
REQ-033 When the wait counter reaches TIMEOUT with mem_ready = 0, the arbiter SHALL assert x_ack = 1, x_err = 1, x_rdata = 0 and return to IDLE.
REQ-034 mem_ready in the timeout cycle SHALL take priority and complete the access normally.
REQ-035 dburst_cnt SHALL increment on each D grant made while i_req = 1, saturating at MAX_DBURST.
REQ-036 dburst_cnt SHALL clear on every I grant, and on any D grant made while i_req = 0.
REQ-037 A non-owning port SHALL see ack = 0, err = 0 and rdata = 0.
REQ-038 mem_ready in IDLE SHALL be ignored.
REQ-039 Request inputs SHALL NOT be required to be stable in IDLE; sampling SHALL occur only at the grant edge.

Reset
REQ-040 On reset = 0, asynchronously: state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, wait counter = 0, dburst_cnt = 0.
REQ-041 Asserting reset mid-access SHALL drop mem_req immediately with no ack issued; an outstanding requester re-requests after reset release.
REQ-042 The first grant SHALL be possible on the first rising edge with reset = 1.

Verification
REQ-043 Single fetch: i_req = 1, i_addr = 0x100, mem_ready 1 cycle after mem_req with mem_rdata = 0x00500093 -> mem_addr = 0x100, mem_we = 0, i_ack for one cycle with i_rdata = 0x00500093, 3 cycles from request to ack.
REQ-044 Contention: i_req and d_req (store, addr 0x2000, data 0xDEADBEEF) asserted together -> D served first with mem_we = 1; I granted on the IDLE after d_ack.
REQ-045 Starvation guard: d_req held continuously, i_req = 1, MAX_DBURST = 4 -> exactly 4 D accesses, then 1 I access, then D resumes.
REQ-046 Timeout: d_req load, mem_ready held 0, TIMEOUT = 8 -> d_ack = d_err = 1 with d_rdata = 0 after 8 BUSY cycles; a separate run with mem_ready = 1 in that cycle -> d_err = 0.
REQ-047 Reset mid-access: reset pulled low during DBUSY -> mem_req = 0 with no clock edge needed, no ack; after release a new i_req is granted normally.
REQ-048 Back-to-back: i_req re-asserted with a new address the cycle after i_ack -> one IDLE cycle, then mem_req with the new address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between an instruction-fetch port and a data port.
// Data wins contention, except that a bounded run of data grants lets a pending fetch in.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int unsigned WCW = 8;
  localparam int unsigned BCW = $clog2(MAX_DBURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [BCW-1:0] dburst_q, dburst_d;
  logic [AW-1:0]  addr_d;
  logic           we_d;
  logic [DW-1:0]  wdata_d;
  logic           timeout_hit;
  logic           dburst_full;

  // State and latched access attributes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      dburst_q  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      dburst_q  <= dburst_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  assign mem_req     = (state_q != IDLE);
  assign timeout_hit = (wait_q == WCW'(TIMEOUT - 1));
  assign dburst_full = (dburst_q == BCW'(MAX_DBURST));

  // Grant decision, completion/abort and per-port responses
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    dburst_d = dburst_q;
    addr_d   = mem_addr;
    we_d     = mem_we;
    wdata_d  = mem_wdata;
    i_ack    = 1'b0;
    i_err    = 1'b0;
    i_rdata  = '0;
    d_ack    = 1'b0;
    d_err    = 1'b0;
    d_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_req && dburst_full)) begin
          state_d = DBUSY;
          wait_d  = '0;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (!i_req)
            dburst_d = '0;
          else if (!dburst_full)
            dburst_d = dburst_q + BCW'(1);
        end else if (i_req) begin
          state_d  = IBUSY;
          wait_d   = '0;
          addr_d   = i_addr;
          we_d     = 1'b0;
          dburst_d = '0;
        end
      end

      IBUSY: begin
        if (mem_ready) begin
          i_ack   = 1'b1;
          i_rdata = mem_rdata;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
          if (timeout_hit) begin
            i_ack   = 1'b1;
            i_err   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DBUSY: begin
        if (mem_ready) begin
          d_ack   = 1'b1;
          d_rdata = mem_we ? '0 : mem_rdata;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
          if (timeout_hit) begin
            d_ack   = 1'b1;
            d_err   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants and
// acks into queues, and an independent monitor compares whatever the DUT presents.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 8;
  localparam int unsigned MAXB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack, i_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack, d_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .MAX_DBURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    bit            chk_wdata;
  } grant_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] rdata;
    logic          err;
  } ack_t;

  grant_t gq[$];
  ack_t   iq[$];
  ack_t   dq[$];

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  bit chk_busy = 1'b0;
  bit exp_busy = 1'b0;

  // Model state: one memory access in flight at most, counted in busy cycles
  bit busy = 1'b0;
  bit owner_d = 1'b0;
  int cnt = 0;
  int lat = 0;
  int dcount = 0;
  bit i_act = 1'b0, d_act = 1'b0;
  bit i_ackd = 1'b0, d_ackd = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_grant(input int c, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] wd, input bit chk_wd);
    grant_t g;
    g.cyc = c; g.addr = a; g.we = we; g.wdata = wd; g.chk_wdata = chk_wd;
    gq.push_back(g);
  endtask

  task automatic push_ack(input bit is_d, input int c, input logic [DW-1:0] rd, input logic err);
    ack_t a;
    a.cyc = c; a.rdata = rd; a.err = err;
    if (is_d) dq.push_back(a);
    else      iq.push_back(a);
  endtask

  function automatic int pick_lat();
    case ($urandom_range(0, 5))
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return int'($urandom_range(1, TO - 1));
      4:       return int'(TO);
      default: return int'(TO) + 3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT activity against the queued predictions
  initial begin : monitor
    logic   prev_req;
    grant_t g;
    ack_t   a;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (chk_busy) check("mem_req_level", mem_req, exp_busy);
        if (mem_req && !prev_req) begin
          if (gq.size() == 0) check("unexpected_grant", 1'b1, 1'b0);
          else begin
            g = gq.pop_front();
            check("grant_cycle", cyc, g.cyc);
            check("mem_addr", mem_addr, g.addr);
            check("mem_we", mem_we, g.we);
            if (g.chk_wdata) check("mem_wdata", mem_wdata, g.wdata);
          end
        end
        if (i_ack) begin
          if (iq.size() == 0) check("unexpected_i_ack", 1'b1, 1'b0);
          else begin
            a = iq.pop_front();
            check("i_ack_cycle", cyc, a.cyc);
            check("i_rdata", i_rdata, a.rdata);
            check("i_err", i_err, a.err);
          end
          check("d_rdata_nonowner", d_rdata, '0);
        end else check("i_err_no_ack", i_err, 1'b0);
        if (d_ack) begin
          if (dq.size() == 0) check("unexpected_d_ack", 1'b1, 1'b0);
          else begin
            a = dq.pop_front();
            check("d_ack_cycle", cyc, a.cyc);
            check("d_rdata", d_rdata, a.rdata);
            check("d_err", d_err, a.err);
          end
          check("i_rdata_nonowner", i_rdata, '0);
        end else check("d_err_no_ack", d_err, 1'b0);
      end
      prev_req = mem_req;
    end
  end

  // Random requesters and memory, with the model predicting each cycle's outcome
  task automatic run_random(input int n, input int i_pct, input int d_pct, input int rep_pct);
    int k;
    bit stop, fin;
    logic [DW-1:0] rd;
    k = 0;
    forever begin
      stop = (k >= n);
      if (stop && !busy && !i_act && !d_act) break;
      if (k >= n + 300) begin
        check("drain_timeout", 1'b1, 1'b0);
        break;
      end
      if (i_ackd) begin
        i_ackd = 1'b0;
        i_act  = !stop && (int'($urandom_range(0, 99)) < rep_pct);
        if (i_act) i_addr = $urandom;
      end else if (!i_act && !stop && int'($urandom_range(0, 99)) < i_pct) begin
        i_act  = 1'b1;
        i_addr = $urandom;
      end
      if (d_ackd) begin
        d_ackd = 1'b0;
        d_act  = !stop && (int'($urandom_range(0, 99)) < rep_pct);
        if (d_act) begin d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom; end
      end else if (!d_act && !stop && int'($urandom_range(0, 99)) < d_pct) begin
        d_act = 1'b1;
        d_addr = $urandom; d_we = 1'($urandom); d_wdata = $urandom;
      end
      i_req = i_act;
      d_req = d_act;
      mem_rdata = $urandom;
      if (!busy) begin
        exp_busy  = 1'b0;
        mem_ready = 1'($urandom);
        if (d_act && !(i_act && dcount == int'(MAXB))) begin
          push_grant(cyc + 1, d_addr, d_we, d_wdata, 1'b1);
          owner_d = 1'b1;
          dcount  = i_act ? ((dcount < int'(MAXB)) ? dcount + 1 : dcount) : 0;
          busy = 1'b1; cnt = 0; lat = pick_lat();
        end else if (i_act) begin
          push_grant(cyc + 1, i_addr, 1'b0, '0, 1'b0);
          owner_d = 1'b0;
          dcount  = 0;
          busy = 1'b1; cnt = 0; lat = pick_lat();
        end
      end else begin
        exp_busy = 1'b1;
        cnt++;
        fin = 1'b0;
        if (cnt == lat) begin
          mem_ready = 1'b1;
          rd = (owner_d && d_we) ? '0 : mem_rdata;
          push_ack(owner_d, cyc, rd, 1'b0);
          fin = 1'b1;
        end else begin
          mem_ready = 1'b0;
          if (cnt == int'(TO)) begin
            push_ack(owner_d, cyc, '0, 1'b1);
            fin = 1'b1;
          end
        end
        if (fin) begin
          busy = 1'b0;
          if (owner_d) d_ackd = 1'b1;
          else         i_ackd = 1'b1;
        end
      end
      step();
      k++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    #12;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);

    @(posedge clk);
    #1;
    reset    = 1'b1;
    mon_on   = 1'b1;
    chk_busy = 1'b1;
    run_random(500, 30, 30, 50);
    run_random(300, 90, 100, 100);
    run_random(200, 20, 20, 30);

    // Reset pulled during a data access: mem_req must fall without a clock edge
    chk_busy = 1'b0;
    d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    mem_ready = 1'b0;
    push_grant(cyc + 1, 32'h2000, 1'b0, 32'hDEADBEEF, 1'b1);
    step();
    step();
    check("mem_req_before_rst", mem_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mem_req_async_rst", mem_req, 1'b0);
    check("mem_addr_async_rst", mem_addr, '0);
    check("d_ack_async_rst", d_ack, 1'b0);
    d_req = 1'b0;
    step();
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h100;
    push_grant(cyc + 1, 32'h100, 1'b0, '0, 1'b0);
    step();
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    push_ack(1'b0, cyc, 32'h00500093, 1'b0);
    step();
    i_req = 1'b0; mem_ready = 1'b0;
    step();
    step();

    check("grant_queue_empty", gq.size(), 0);
    check("i_ack_queue_empty", iq.size(), 0);
    check("d_ack_queue_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
